// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port word RAM (1 write port, 1 read port) among NREQ requesters.
// Latency: grant/req_ready combinational in the request cycle; read data + one-hot rsp_valid 1 cycle after acceptance.
// Backpressure: req_ready only to the winner of each port; responses have no backpressure (requesters always accept).
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_we/req_addr/req_wdata/req_ready   per-requester request channel (packed, requester i at slot i)
//   rsp_valid (one-hot), rsp_data                   read response, shared data bus
//   ram_wraddress/ram_wren/ram_data                 RAM write port
//   ram_rdaddress/ram_q                             RAM read port (ram_q registered, 1 cycle after address)
module ram_port_arbiter #(
   parameter int NREQ = 2,
   parameter int DW   = 64,
   parameter int AW   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [DW-1:0]     rsp_data,
   output logic [AW-1:0]     ram_wraddress,
   output logic              ram_wren,
   output logic [DW-1:0]     ram_data,
   output logic [AW-1:0]     ram_rdaddress,
   input  logic [DW-1:0]     ram_q
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   wptr, rptr;
   logic [PW-1:0]   widx, ridx;
   logic [NREQ-1:0] wcand, rcand;
   logic [NREQ-1:0] wgnt, rgnt;
   logic            wany, rany;

   // First candidate at or above ptr, wrapping to 0. With no candidate the
   // pointer requester is returned so the RAM fields stay driven.
   function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] cand,
                                             input logic [PW-1:0]   ptr);
      logic [PW-1:0] pick;
      logic [PW-1:0] idx;
      logic          hit;
      pick = ptr;
      hit  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!hit && cand[idx]) begin
            hit  = 1'b1;
            pick = idx;
         end
      end
      return pick;
   endfunction

   // (g+1) mod NREQ; collapses to constant 0 when NREQ == 1.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] g);
      if (int'(g) >= NREQ - 1) return '0;
      return g + 1'b1;
   endfunction

   assign wcand = req_valid & req_we;
   assign rcand = req_valid & ~req_we;
   assign wany  = |wcand;
   assign rany  = |rcand;
   assign widx  = rr_pick(wcand, wptr);
   assign ridx  = rr_pick(rcand, rptr);

   always_comb begin
      wgnt = '0;
      rgnt = '0;
      if (wany) wgnt[widx] = 1'b1;
      if (rany) rgnt[ridx] = 1'b1;
   end

   // A requester is in exactly one class per cycle, so the two grants never overlap.
   assign req_ready     = (wgnt | rgnt) & {NREQ{~rst}};

   assign ram_wren      = wany & ~rst;
   assign ram_wraddress = req_addr[int'(widx)*AW +: AW];
   assign ram_data      = req_wdata[int'(widx)*DW +: DW];
   assign ram_rdaddress = req_addr[int'(ridx)*AW +: AW];

   // RAM read data is already registered; only the valid needs a stage to line up.
   assign rsp_data      = ram_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         rsp_valid <= '0;
      end else begin
         if (wany) wptr <= ptr_next(widx);
         if (rany) rptr <= ptr_next(ridx);
         rsp_valid <= rgnt;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: NREQ=2 and NREQ=3 instances, each with a behavioural RAM.
// Expected read responses are queued at acceptance from a reference memory and compared one cycle later.
// Grant patterns are checked against fixed expected req_ready sequences.
module tb_ram_port_arbiter;
   localparam int DW = 64;
   localparam int AW = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // ---------------- NREQ = 2 instance ----------------
   logic [1:0]      v2, we2, rdy2, rv2;
   logic [2*AW-1:0] a2;
   logic [2*DW-1:0] wd2;
   logic [DW-1:0]   rd2, q2, wdat2;
   logic [AW-1:0]   wa2, ra2;
   logic            wen2;
   logic [DW-1:0]   mem2 [64];
   logic [DW-1:0]   ref2 [64];
   logic [1:0]      q2v [$];
   logic [DW-1:0]   q2d [$];

   ram_port_arbiter #(.NREQ(2), .DW(DW), .AW(AW)) u_dut2 (
      .clk(clk), .rst(rst), .req_valid(v2), .req_we(we2), .req_addr(a2), .req_wdata(wd2),
      .req_ready(rdy2), .rsp_valid(rv2), .rsp_data(rd2), .ram_wraddress(wa2), .ram_wren(wen2),
      .ram_data(wdat2), .ram_rdaddress(ra2), .ram_q(q2));

   always @(posedge clk) begin
      if (wen2) mem2[wa2] <= wdat2;
      q2 <= mem2[ra2];
   end

   // ---------------- NREQ = 3 instance ----------------
   logic [2:0]      v3, we3, rdy3, rv3;
   logic [3*AW-1:0] a3;
   logic [3*DW-1:0] wd3;
   logic [DW-1:0]   rd3, q3, wdat3;
   logic [AW-1:0]   wa3, ra3;
   logic            wen3;
   logic [DW-1:0]   mem3 [64];
   logic [DW-1:0]   ref3 [64];
   logic [2:0]      q3v [$];
   logic [DW-1:0]   q3d [$];

   ram_port_arbiter #(.NREQ(3), .DW(DW), .AW(AW)) u_dut3 (
      .clk(clk), .rst(rst), .req_valid(v3), .req_we(we3), .req_addr(a3), .req_wdata(wd3),
      .req_ready(rdy3), .rsp_valid(rv3), .rsp_data(rd3), .ram_wraddress(wa3), .ram_wren(wen3),
      .ram_data(wdat3), .ram_rdaddress(ra3), .ram_q(q3));

   always @(posedge clk) begin
      if (wen3) mem3[wa3] <= wdat3;
      q3 <= mem3[ra3];
   end

   task automatic drive2(input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      v2 = v; we2 = we; a2 = {ad1, ad0}; wd2 = {d1, d0};
   endtask

   // Check combinational grant, record accepted ops in the scoreboard, clock once, check response.
   task automatic step2(input logic [1:0] exp_rdy, input logic exp_wen);
      logic [AW-1:0] ad;
      #1;
      chk("rdy2", 64'(rdy2), 64'(exp_rdy));
      chk("wen2", 64'(wen2), 64'(exp_wen));
      for (int i = 0; i < 2; i++) begin
         ad = a2[i*AW +: AW];
         if (v2[i] && rdy2[i] && !we2[i]) begin
            q2v.push_back(2'(1 << i));
            q2d.push_back(ref2[ad]);
         end
      end
      // Writes applied after reads: same-cycle read returns the old word.
      for (int i = 0; i < 2; i++) begin
         ad = a2[i*AW +: AW];
         if (v2[i] && rdy2[i] && we2[i]) ref2[ad] = wd2[i*DW +: DW];
      end
      @(posedge clk); #1;
      if (q2v.size() > 0) begin
         chk("rsp_valid2", 64'(rv2), 64'(q2v.pop_front()));
         chk("rsp_data2", rd2, q2d.pop_front());
      end else begin
         chk("rsp_idle2", 64'(rv2), 64'd0);
      end
   endtask

   task automatic drive3(input logic [2:0] v, input logic [2:0] we, input logic [DW-1:0] d);
      v3 = v; we3 = we; wd3 = {d + 64'd2, d + 64'd1, d};
      a3 = {6'd32, 6'd31, 6'd30};
   endtask

   task automatic step3(input logic [2:0] exp_rdy, input logic exp_wen);
      logic [AW-1:0] ad;
      #1;
      chk("rdy3", 64'(rdy3), 64'(exp_rdy));
      chk("wen3", 64'(wen3), 64'(exp_wen));
      for (int i = 0; i < 3; i++) begin
         ad = a3[i*AW +: AW];
         if (v3[i] && rdy3[i] && !we3[i]) begin
            q3v.push_back(3'(1 << i));
            q3d.push_back(ref3[ad]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         ad = a3[i*AW +: AW];
         if (v3[i] && rdy3[i] && we3[i]) ref3[ad] = wd3[i*DW +: DW];
      end
      @(posedge clk); #1;
      if (q3v.size() > 0) begin
         chk("rsp_valid3", 64'(rv3), 64'(q3v.pop_front()));
         chk("rsp_data3", rd3, q3d.pop_front());
      end else begin
         chk("rsp_idle3", 64'(rv3), 64'd0);
      end
   endtask

   task automatic pulse_reset();
      v2 = '0; v3 = '0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] a0, a1;
      logic [AW-1:0] rb [4];
      v2 = '0; we2 = '0; a2 = '0; wd2 = '0;
      v3 = '0; we3 = '0; a3 = '0; wd3 = '0;

      // Reset state, with requests presented: nothing may be granted.
      rst = 1'b1;
      drive2(2'b11, 2'b01, 6'd5, 6'd5, 64'd1, 64'd0);
      drive3(3'b111, 3'b001, 64'd7);
      #2;
      chk("rst_rdy2", 64'(rdy2), 64'd0);
      chk("rst_wen2", 64'(wen2), 64'd0);
      chk("rst_rv2", 64'(rv2), 64'd0);
      chk("rst_rdy3", 64'(rdy3), 64'd0);
      chk("rst_wen3", 64'(wen3), 64'd0);
      chk("rst_rv3", 64'(rv3), 64'd0);
      v2 = '0; v3 = '0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Write then read back through another requester.
      drive2(2'b01, 2'b01, 6'd5, 6'd0, 64'hA5, 64'd0);
      step2(2'b01, 1'b1);
      drive2(2'b10, 2'b00, 6'd0, 6'd5, 64'd0, 64'd0);
      step2(2'b10, 1'b0);

      // Continuous writes from both: grants alternate 0,1,0,1.
      pulse_reset();
      for (int k = 0; k < 4; k++) begin
         a0 = AW'(10 + (k + 1) / 2);
         a1 = AW'(20 + k / 2);
         drive2(2'b11, 2'b11, a0, a1, 64'hC0DE_0000_0000_0000 | 64'(a0),
                64'hBEEF_0000_0000_0000 | 64'(a1));
         step2((k % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
      end
      rb[0] = 6'd10; rb[1] = 6'd11; rb[2] = 6'd20; rb[3] = 6'd21;
      for (int k = 0; k < 4; k++) begin
         drive2(2'b01, 2'b00, rb[k], 6'd0, 64'd0, 64'd0);
         step2(2'b01, 1'b0);
      end

      // Same-address write and read in one cycle: read sees the old word.
      drive2(2'b01, 2'b01, 6'd3, 6'd0, 64'h22, 64'd0);
      step2(2'b01, 1'b1);
      drive2(2'b11, 2'b01, 6'd3, 6'd3, 64'h11, 64'd0);
      step2(2'b11, 1'b1);
      drive2(2'b10, 2'b00, 6'd0, 6'd3, 64'd0, 64'd0);
      step2(2'b10, 1'b0);

      // Read by requester 0 leaves rptr at 1; reset while its response is showing.
      drive2(2'b01, 2'b00, 6'd3, 6'd0, 64'd0, 64'd0);
      step2(2'b01, 1'b0);
      drive2(2'b11, 2'b01, 6'd3, 6'd10, 64'h99, 64'd0);
      rst = 1'b1;
      #1;
      chk("arst_rv2", 64'(rv2), 64'd0);
      chk("arst_rdy2", 64'(rdy2), 64'd0);
      chk("arst_wen2", 64'(wen2), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      // rptr back at 0: requester 0 wins the read tie.
      drive2(2'b11, 2'b00, 6'd3, 6'd10, 64'd0, 64'd0);
      step2(2'b01, 1'b0);

      // Idle cycles must not move either pointer (rptr=1, wptr=0 here).
      for (int k = 0; k < 2; k++) begin
         drive2(2'b00, 2'b00, 6'd3, 6'd10, 64'd0, 64'd0);
         step2(2'b00, 1'b0);
      end
      drive2(2'b11, 2'b00, 6'd3, 6'd10, 64'd0, 64'd0);
      step2(2'b10, 1'b0);
      drive2(2'b11, 2'b11, 6'd40, 6'd41, 64'h4040, 64'h4141);
      step2(2'b01, 1'b1);
      drive2(2'b00, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0);
      step2(2'b00, 1'b0);
      drive2(2'b11, 2'b11, 6'd42, 6'd41, 64'h4242, 64'h4141);
      step2(2'b10, 1'b1);
      drive2(2'b01, 2'b00, 6'd41, 6'd0, 64'd0, 64'd0);
      step2(2'b01, 1'b0);

      // Three requesters: preload 30..32, then all read every cycle.
      for (int i = 0; i < 3; i++) begin
         drive3(3'(1 << i), 3'(1 << i), 64'h3000_0000_0000_5A00);
         step3(3'(1 << i), 1'b1);
      end
      for (int k = 0; k < 6; k++) begin
         drive3(3'b111, 3'b000, 64'd0);
         step3(3'(1 << (k % 3)), 1'b0);
      end
      drive3(3'b000, 3'b000, 64'd0);
      step3(3'b000, 1'b0);

      chk("q2_drained", 64'(q2v.size()), 64'd0);
      chk("q3_drained", 64'(q3v.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
